// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch front end.
//
// Owns the fetch PC and issues one word request per accepted handshake on a
// valid/ack channel whose responses return in order. Returned words are
// buffered in a small FIFO whose head feeds the IF/ID register. Branch/jump
// redirects, interrupt entry and exception return flush the FIFO and cause
// any responses still in flight to be discarded as they arrive.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   pause        IF/ID stall; head is held while 1
//   IntReq       interrupt taken -> redirect to INT_VEC
//   EXLClr       eret executed   -> redirect to epc
//   epc          exception return address
//   br_taken     branch/jump redirect request
//   br_target    branch/jump target
//   imem_req     request valid
//   imem_addr    request word address
//   imem_ack     request accepted this cycle
//   imem_rvalid  response valid (in order)
//   imem_rdata   response word
//   new_code     head instruction, 0 (nop) when empty
//   pc           head PC, fetch PC when empty
//   f_valid      FIFO non-empty
module if_fetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] INT_VEC  = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pause,
  input  logic        IntReq,
  input  logic        EXLClr,
  input  logic [31:0] epc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] new_code,
  output logic [31:0] pc,
  output logic        f_valid
);

  // DEPTH is 2..4, so two pointer bits and three count bits always suffice.
  localparam int unsigned PtrW   = (DEPTH > 2) ? 2 : 1;
  localparam logic [3:0]  DepthL = 4'(DEPTH);

  typedef logic [PtrW-1:0] ptr_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    if (32'(p) == DEPTH - 1) begin
      return '0;
    end
    return p + ptr_t'(1);
  endfunction

  // Architectural state
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [2:0]  inflight_q, inflight_d;
  logic [2:0]  discard_q,  discard_d;
  logic [2:0]  count_q,    count_d;
  logic        run_q;

  // Tag FIFO: PCs of live (non-discarded) in-flight requests
  ptr_t        tag_wptr_q, tag_wptr_d;
  ptr_t        tag_rptr_q, tag_rptr_d;
  logic [31:0] tag_mem [DEPTH];

  // Data FIFO: (pc, code) pairs ready for decode
  ptr_t        dat_wptr_q, dat_wptr_d;
  ptr_t        dat_rptr_q, dat_rptr_d;
  logic [31:0] dpc_mem  [DEPTH];
  logic [31:0] dcode_mem[DEPTH];

  // Control
  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;
  logic        pop;
  logic [3:0]  occ;
  logic        issue;
  logic        ack;
  logic        rsp_drop;
  logic        rsp_keep;
  logic        push;

  always_comb begin
    redirect = EXLClr | IntReq | br_taken;
    if (EXLClr) begin
      target_raw = epc;
    end else if (IntReq) begin
      target_raw = INT_VEC;
    end else begin
      target_raw = br_target;
    end
    target = target_raw & ~32'h3;

    f_valid = (count_q != 3'd0);
    pop     = f_valid & ~pause;

    // Credit: words in flight plus buffered, after this cycle's pop, must
    // leave room so every response can be pushed without overflow.
    occ   = {1'b0, inflight_q} + {1'b0, count_q} - {3'b000, pop};
    issue = ~redirect & (occ < DepthL);

    // run_q keeps the request low during reset and the release cycle.
    imem_req  = issue & run_q;
    imem_addr = fetch_pc_q;
    ack       = imem_req & imem_ack;

    rsp_drop = imem_rvalid & (discard_q != 3'd0);
    rsp_keep = imem_rvalid & ~rsp_drop;
    push     = rsp_keep & ~redirect;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q + {2'b00, ack} - {2'b00, imem_rvalid};
    discard_d  = discard_q;
    count_d    = count_q;
    tag_wptr_d = tag_wptr_q;
    tag_rptr_d = tag_rptr_q;
    dat_wptr_d = dat_wptr_q;
    dat_rptr_d = dat_rptr_q;

    if (redirect) begin
      // Everything still outstanding at cycle end is stale. The tag FIFO is
      // emptied since discarded responses never consume a tag.
      fetch_pc_d = target;
      discard_d  = inflight_d;
      count_d    = 3'd0;
      tag_wptr_d = '0;
      tag_rptr_d = '0;
      dat_wptr_d = '0;
      dat_rptr_d = '0;
    end else begin
      if (ack) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        tag_wptr_d = ptr_inc(tag_wptr_q);
      end
      if (rsp_drop) begin
        discard_d = discard_q - 3'd1;
      end
      if (rsp_keep) begin
        tag_rptr_d = ptr_inc(tag_rptr_q);
      end
      if (push) begin
        dat_wptr_d = ptr_inc(dat_wptr_q);
      end
      if (pop) begin
        dat_rptr_d = ptr_inc(dat_rptr_q);
      end
      count_d = count_q + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 3'd0;
      discard_q  <= 3'd0;
      count_q    <= 3'd0;
      run_q      <= 1'b0;
      tag_wptr_q <= '0;
      tag_rptr_q <= '0;
      dat_wptr_q <= '0;
      dat_rptr_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      run_q      <= 1'b1;
      tag_wptr_q <= tag_wptr_d;
      tag_rptr_q <= tag_rptr_d;
      dat_wptr_q <= dat_wptr_d;
      dat_rptr_q <= dat_rptr_d;
    end
  end

  // Storage needs no reset: entries are only observed through valid counts.
  always_ff @(posedge clk) begin
    if (ack) begin
      tag_mem[tag_wptr_q] <= fetch_pc_q;
    end
    if (push) begin
      dpc_mem[dat_wptr_q]   <= tag_mem[tag_rptr_q];
      dcode_mem[dat_wptr_q] <= imem_rdata;
    end
  end

  always_comb begin
    if (f_valid) begin
      pc       = dpc_mem[dat_rptr_q];
      new_code = dcode_mem[dat_rptr_q];
    end else begin
      pc       = fetch_pc_q;
      new_code = 32'h0;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an in-order memory model of
// configurable response latency.
module tb_if_fetch_unit;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] INT_VEC  = 32'h0000_4180;

  logic        clk;
  logic        reset = 1'b0;
  logic        pause = 1'b0;
  logic        IntReq = 1'b0;
  logic        EXLClr = 1'b0;
  logic        br_taken = 1'b0;
  logic        imem_ack = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] epc = 32'h0;
  logic [31:0] br_target = 32'h0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic        f_valid;
  logic [31:0] imem_addr;
  logic [31:0] new_code;
  logic [31:0] pc;

  int n_checks = 0;
  int n_pass   = 0;

  int          mem_lat = 1;
  int          cyc = 0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  if_fetch_unit #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC),
    .INT_VEC (INT_VEC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pause      (pause),
    .IntReq     (IntReq),
    .EXLClr     (EXLClr),
    .epc        (epc),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .new_code   (new_code),
    .pc         (pc),
    .f_valid    (f_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] code_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory: drives a response just after each rising edge, samples the
  // handshake just before the next one. Response arrives mem_lat cycles
  // after the ack.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!reset) begin
        mq_addr.delete();
        mq_due.delete();
      end
      if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = code_of(mq_addr[0]);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end
      #7;
      if (!reset) begin
        mq_addr.delete();
        mq_due.delete();
        imem_rvalid = 1'b0;
      end else begin
        if (imem_rvalid) begin
          void'(mq_addr.pop_front());
          void'(mq_due.pop_front());
        end
        if (imem_req && imem_ack) begin
          mq_addr.push_back(imem_addr);
          mq_due.push_back(cyc + mem_lat);
        end
      end
    end
  end

  // Returns at the negedge of the first cycle in which a request may issue.
  task automatic do_reset(input int lat);
    reset    = 1'b0;
    pause    = 1'b0;
    IntReq   = 1'b0;
    EXLClr   = 1'b0;
    br_taken = 1'b0;
    imem_ack = 1'b1;
    mem_lat  = lat;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req);
    else n_pass++;
    n_checks++;
    if (f_valid !== 1'b0) $display("FAIL reset_fvalid: got %b want 0", f_valid);
    else n_pass++;
    n_checks++;
    if (new_code !== 32'h0) $display("FAIL reset_code: got %h want 0", new_code);
    else n_pass++;
    n_checks++;
    if (pc !== RESET_PC) $display("FAIL reset_pc: got %h want %h", pc, RESET_PC);
    else n_pass++;
  endtask

  task automatic test_stream();
    logic [31:0] e;
    mem_lat = 1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL stream_release_req: got %b want 0", imem_req);
    else n_pass++;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      #1;
      e = RESET_PC + 32'(4 * k);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== e)
        $display("FAIL stream_req k=%0d: got req=%b addr=%h want req=1 addr=%h",
                 k, imem_req, imem_addr, e);
      else n_pass++;
      if (k >= 2) begin
        e = RESET_PC + 32'(4 * (k - 2));
        n_checks++;
        if (f_valid !== 1'b1 || pc !== e || new_code !== code_of(e))
          $display("FAIL stream_head k=%0d: got v=%b pc=%h code=%h want v=1 pc=%h code=%h",
                   k, f_valid, pc, new_code, e, code_of(e));
        else n_pass++;
      end else begin
        n_checks++;
        if (f_valid !== 1'b0) $display("FAIL stream_empty k=%0d: got %b want 0", k, f_valid);
        else n_pass++;
      end
    end
  endtask

  task automatic test_pause();
    logic [31:0] e;
    do_reset(1);
    #1;
    @(negedge clk);
    #1;
    @(negedge clk);
    pause = 1'b1;
    #1;
    n_checks++;
    if (f_valid !== 1'b1 || pc !== RESET_PC || imem_req !== 1'b0)
      $display("FAIL pause_start: got v=%b pc=%h req=%b want v=1 pc=%h req=0",
               f_valid, pc, imem_req, RESET_PC);
    else n_pass++;
    for (int k = 3; k <= 6; k++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (f_valid !== 1'b1 || pc !== RESET_PC || new_code !== code_of(RESET_PC) ||
          imem_req !== 1'b0)
        $display("FAIL pause_hold k=%0d: got v=%b pc=%h code=%h req=%b want v=1 pc=%h req=0",
                 k, f_valid, pc, new_code, imem_req, RESET_PC);
      else n_pass++;
    end
    @(negedge clk);
    pause = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3008 || pc !== RESET_PC)
      $display("FAIL pause_release: got req=%b addr=%h pc=%h want req=1 addr=3008 pc=3000",
               imem_req, imem_addr, pc);
    else n_pass++;
    for (int k = 8; k <= 10; k++) begin
      @(negedge clk);
      #1;
      e = RESET_PC + 32'(4 * (k - 7));
      n_checks++;
      if (f_valid !== 1'b1 || pc !== e || new_code !== code_of(e))
        $display("FAIL pause_resume k=%0d: got v=%b pc=%h code=%h want pc=%h",
                 k, f_valid, pc, new_code, e);
      else n_pass++;
    end
  endtask

  task automatic test_redirect();
    bit seen;
    do_reset(3);
    #1;
    @(negedge clk);
    #1;
    @(negedge clk);
    br_taken  = 1'b1;
    br_target = 32'h0000_3102;
    #1;
    n_checks++;
    if (mq_addr.size() != 2) $display("FAIL redir_inflight: got %0d want 2", mq_addr.size());
    else n_pass++;
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL redir_req_low: got %b want 0", imem_req);
    else n_pass++;
    @(negedge clk);
    br_taken = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || f_valid !== 1'b0 || pc !== 32'h3100)
      $display("FAIL redir_drain: got req=%b v=%b pc=%h want req=0 v=0 pc=3100",
               imem_req, f_valid, pc);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3100)
      $display("FAIL redir_addr: got req=%b addr=%h want req=1 addr=3100", imem_req, imem_addr);
    else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (f_valid === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) $display("FAIL redir_timeout: got no f_valid want f_valid within 12 cycles");
    else n_pass++;
    if (seen) begin
      n_checks++;
      if (pc !== 32'h3100 || new_code !== code_of(32'h3100))
        $display("FAIL redir_head: got pc=%h code=%h want pc=3100 code=%h",
                 pc, new_code, code_of(32'h3100));
      else n_pass++;
    end
  endtask

  task automatic test_priority();
    do_reset(1);
    #1;
    @(negedge clk);
    #1;
    @(negedge clk);
    #1;
    @(negedge clk);
    EXLClr    = 1'b1;
    IntReq    = 1'b1;
    br_taken  = 1'b1;
    epc       = 32'h0000_3050;
    br_target = 32'h0000_3200;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL prio_req_low: got %b want 0", imem_req);
    else n_pass++;
    @(negedge clk);
    EXLClr   = 1'b0;
    IntReq   = 1'b0;
    br_taken = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h3050)
      $display("FAIL prio_epc_addr: got req=%b addr=%h want req=1 addr=3050", imem_req, imem_addr);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (f_valid !== 1'b0 || pc !== 32'h3054)
      $display("FAIL prio_gap: got v=%b pc=%h want v=0 pc=3054", f_valid, pc);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (f_valid !== 1'b1 || pc !== 32'h3050 || new_code !== code_of(32'h3050))
      $display("FAIL prio_epc_head: got v=%b pc=%h code=%h want v=1 pc=3050", f_valid, pc, new_code);
    else n_pass++;
    @(negedge clk);
    IntReq = 1'b1;
    #1;
    @(negedge clk);
    IntReq = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== INT_VEC)
      $display("FAIL prio_int_addr: got req=%b addr=%h want req=1 addr=%h",
               imem_req, imem_addr, INT_VEC);
    else n_pass++;
    @(negedge clk);
    #1;
    @(negedge clk);
    #1;
    n_checks++;
    if (f_valid !== 1'b1 || pc !== INT_VEC || new_code !== code_of(INT_VEC))
      $display("FAIL prio_int_head: got v=%b pc=%h code=%h want v=1 pc=%h",
               f_valid, pc, new_code, INT_VEC);
    else n_pass++;
  endtask

  task automatic test_latency3();
    logic [31:0] e;
    int got;
    do_reset(3);
    e   = RESET_PC;
    got = 0;
    for (int k = 0; k < 80; k++) begin
      if (k > 0) @(negedge clk);
      pause    = (k % 7 == 3);
      imem_ack = (k % 4 != 2);
      #1;
      n_checks++;
      if (mq_addr.size() > int'(DEPTH))
        $display("FAIL lat3_outstanding k=%0d: got %0d want <= %0d", k, mq_addr.size(), DEPTH);
      else n_pass++;
      if (f_valid === 1'b1 && !pause) begin
        n_checks++;
        if (pc !== e || new_code !== code_of(e))
          $display("FAIL lat3_order k=%0d: got pc=%h code=%h want pc=%h code=%h",
                   k, pc, new_code, e, code_of(e));
        else n_pass++;
        e = e + 32'd4;
        got++;
      end
    end
    pause    = 1'b0;
    imem_ack = 1'b1;
    n_checks++;
    if (got < 15) $display("FAIL lat3_progress: got %0d words want >= 15", got);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset(3);
    #1;
    @(negedge clk);
    #1;
    @(negedge clk);
    #1;
    n_checks++;
    if (pc !== 32'h3008 || mq_addr.size() != 2)
      $display("FAIL rmid_pre: got pc=%h inflight=%0d want pc=3008 inflight=2", pc, mq_addr.size());
    else n_pass++;
    #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || f_valid !== 1'b0 || pc !== RESET_PC || new_code !== 32'h0)
      $display("FAIL rmid_async: got req=%b v=%b pc=%h code=%h want req=0 v=0 pc=%h code=0",
               imem_req, f_valid, pc, new_code, RESET_PC);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL rmid_release: got req=%b want 0", imem_req);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC)
      $display("FAIL rmid_refetch: got req=%b addr=%h want req=1 addr=%h",
               imem_req, imem_addr, RESET_PC);
    else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (f_valid === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) $display("FAIL rmid_timeout: got no f_valid want f_valid within 12 cycles");
    else n_pass++;
    if (seen) begin
      n_checks++;
      if (pc !== RESET_PC || new_code !== code_of(RESET_PC))
        $display("FAIL rmid_head: got pc=%h code=%h want pc=%h code=%h",
                 pc, new_code, RESET_PC, code_of(RESET_PC));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_pause();
    test_redirect();
    test_priority();
    test_latency3();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
